os_pe: RTL and testbench

OS_PE -- requirements
Module: os_pe

---
 rtl/os_pe.sv | 31 +++
 tb/tb_os_pe.sv | 136 +++++++++++++
 2 files changed

// File: rtl/os_pe.sv
// os_pe: output-stationary systolic PE; forwards operands east/south and accumulates their product locally.
module os_pe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstnPipe,
    input  logic             rstnPsum,
    input  logic [WIDTH-1:0] ipA,
    input  logic [WIDTH-1:0] ipB,
    output logic [WIDTH-1:0] opA,
    output logic [WIDTH-1:0] opB,
    output logic [WIDTH-1:0] opC
);
    logic [WIDTH-1:0] prod;

    // The product uses the live inputs, so a PE's MAC is not delayed behind its own forwarding registers.
    assign prod = ipA * ipB;

    always_ff @(posedge clk or posedge rstnPipe)
        if (rstnPipe) begin
            opA <= '0;
            opB <= '0;
        end else begin
            opA <= ipA;
            opB <= ipB;
        end

    always_ff @(posedge clk or posedge rstnPsum)
        if (rstnPsum) opC <= '0;
        else          opC <= opC + prod;
endmodule

// File: tb/tb_os_pe.sv
// tb_os_pe: directed vector table, async-reset sequences and randomized run against an arithmetic model of os_pe.
module tb_os_pe;
    logic        clk = 1'b0;
    logic        rstnPipe, rstnPsum;
    logic [31:0] ipA, ipB, opA, opB, opC;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        string       name;
        logic        pr;
        logic        sr;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [31:0] ec;
    } vec_t;

    vec_t tbl[$];

    os_pe #(.WIDTH(32)) dut (
        .clk(clk), .rstnPipe(rstnPipe), .rstnPsum(rstnPsum),
        .ipA(ipA), .ipB(ipB), .opA(opA), .opB(opB), .opC(opC)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic applyVec(input vec_t v);
        @(negedge clk);
        rstnPipe = v.pr;
        rstnPsum = v.sr;
        ipA = v.a;
        ipB = v.b;
        @(posedge clk);
        #1;
        check({v.name, ".opA"}, opA, v.ea);
        check({v.name, ".opB"}, opB, v.eb);
        check({v.name, ".opC"}, opC, v.ec);
    endtask

    initial begin
        logic [31:0] mA, mB, mC;
        logic        pr, sr;
        logic [31:0] a, b;
        // Resets asserted with the clock still low: outputs clear immediately.
        rstnPipe = 1'b1;
        rstnPsum = 1'b1;
        ipA = 32'd0;
        ipB = 32'd0;
        #2;
        check("rst.opA", opA, 32'd0);
        check("rst.opB", opB, 32'd0);
        check("rst.opC", opC, 32'd0);

        tbl.push_back('{"one",    1'b0, 1'b0, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1});
        tbl.push_back('{"zero",   1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1});
        tbl.push_back('{"clr",    1'b1, 1'b1, 32'd6, 32'd6, 32'd0, 32'd0, 32'd0});
        tbl.push_back('{"m35",    1'b0, 1'b0, 32'd3, 32'd5, 32'd3, 32'd5, 32'd15});
        tbl.push_back('{"m27",    1'b0, 1'b0, 32'd2, 32'd7, 32'd2, 32'd7, 32'd29});
        foreach (tbl[i]) applyVec(tbl[i]);

        // Pipeline reset alone leaves the sum; then sum reset clears it, both without a clock edge.
        @(negedge clk);
        ipA = 32'd0;
        ipB = 32'd0;
        #1 rstnPipe = 1'b1;
        #1;
        check("pipeRst.opA", opA, 32'd0);
        check("pipeRst.opB", opB, 32'd0);
        check("pipeRst.opC", opC, 32'd29);
        rstnPsum = 1'b1;
        #1;
        check("psumRst.opC", opC, 32'd0);

        // Deassertion waits for the next edge.
        @(negedge clk);
        rstnPipe = 1'b0;
        rstnPsum = 1'b0;
        ipA = 32'd9;
        ipB = 32'd2;
        #2;
        check("relHold.opA", opA, 32'd0);
        check("relHold.opC", opC, 32'd0);
        @(posedge clk);
        #1;
        check("relEdge.opA", opA, 32'd9);
        check("relEdge.opC", opC, 32'd18);

        tbl.delete();
        tbl.push_back('{"clr2",   1'b1, 1'b1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0});
        tbl.push_back('{"wrapMax",1'b0, 1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF});
        tbl.push_back('{"wrap0",  1'b0, 1'b0, 32'd1, 32'd1, 32'd1, 32'd1, 32'd0});
        tbl.push_back('{"trunc",  1'b0, 1'b0, 32'h10000, 32'h10000, 32'h10000, 32'h10000, 32'd0});
        tbl.push_back('{"clr3",   1'b0, 1'b1, 32'd5, 32'd5, 32'd5, 32'd5, 32'd0});
        tbl.push_back('{"pr16",   1'b1, 1'b0, 32'd4, 32'd4, 32'd0, 32'd0, 32'd16});
        tbl.push_back('{"pr32",   1'b1, 1'b0, 32'd4, 32'd4, 32'd0, 32'd0, 32'd32});
        tbl.push_back('{"both",   1'b1, 1'b1, 32'd4, 32'd4, 32'd0, 32'd0, 32'd0});
        foreach (tbl[i]) applyVec(tbl[i]);

        // Randomized run: model holds the state after each edge from the accumulation rules.
        mA = 32'd0;
        mB = 32'd0;
        mC = 32'd0;
        for (int n = 0; n < 300; n++) begin
            pr = ($urandom_range(0, 9) == 0);
            sr = ($urandom_range(0, 14) == 0);
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            @(negedge clk);
            rstnPipe = pr;
            rstnPsum = sr;
            ipA = a;
            ipB = b;
            mA = pr ? 32'd0 : a;
            mB = pr ? 32'd0 : b;
            mC = sr ? 32'd0 : 32'((64'(mC) + 64'(a) * 64'(b)) % 64'h1_0000_0000);
            @(posedge clk);
            #1;
            check("rnd.opA", opA, mA);
            check("rnd.opB", opB, mB);
            check("rnd.opC", opC, mC);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
